// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: control-word bit map, masks, opcodes and widths.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
package sap_pkg;

    // Bus and register widths; the RAM address is always 4 bits.
    localparam int SAP_DATA_W    = 8;
    localparam int SAP_ADDR_W    = 4;
    localparam int SAP_RAM_DEPTH = 16;
    localparam int CW_W          = 16;

    // Control-word bit positions.
    localparam int CW_HALT = 15;
    localparam int CW_MI   = 14;
    localparam int CW_RI   = 13;
    localparam int CW_RO   = 12;
    localparam int CW_IO   = 11;
    localparam int CW_II   = 10;
    localparam int CW_AI   = 9;
    localparam int CW_AO   = 8;
    localparam int CW_SMO  = 7;
    localparam int CW_SUB  = 6;
    localparam int CW_BI   = 5;
    localparam int CW_OI   = 4;
    localparam int CW_CE   = 3;
    localparam int CW_CO   = 2;

    // Single-bit masks, OR-ed together to build micro-step words.
    localparam logic [CW_W-1:0] M_HALT = 16'h8000;
    localparam logic [CW_W-1:0] M_MI   = 16'h4000;
    localparam logic [CW_W-1:0] M_RI   = 16'h2000;
    localparam logic [CW_W-1:0] M_RO   = 16'h1000;
    localparam logic [CW_W-1:0] M_IO   = 16'h0800;
    localparam logic [CW_W-1:0] M_II   = 16'h0400;
    localparam logic [CW_W-1:0] M_AI   = 16'h0200;
    localparam logic [CW_W-1:0] M_AO   = 16'h0100;
    localparam logic [CW_W-1:0] M_SMO  = 16'h0080;
    localparam logic [CW_W-1:0] M_SUB  = 16'h0040;
    localparam logic [CW_W-1:0] M_BI   = 16'h0020;
    localparam logic [CW_W-1:0] M_OI   = 16'h0010;
    localparam logic [CW_W-1:0] M_CE   = 16'h0008;
    localparam logic [CW_W-1:0] M_CO   = 16'h0004;

    // Opcodes carried in IR[7:4].
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;

    // Control word viewed field by field; MSB first so it matches the bit map.
    typedef struct packed {
        logic       halt;
        logic       mi;
        logic       ri;
        logic       ro;
        logic       io;
        logic       ii;
        logic       ai;
        logic       ao;
        logic       smo;
        logic       sub;
        logic       bi;
        logic       oi;
        logic       ce;
        logic       co;
        logic [1:0] rsvd;
    } ctrl_t;

    // Which source owns the shared bus this cycle.
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_RAM  = 3'd1,
        SRC_IR   = 3'd2,
        SRC_A    = 3'd3,
        SRC_ALU  = 3'd4,
        SRC_PC   = 3'd5
    } bus_src_e;

    // Number of bus drivers requested by a control word (0..5).
    function automatic logic [2:0] driver_count(input ctrl_t c);
        driver_count = {2'b00, c.ro} + {2'b00, c.io} + {2'b00, c.ao}
                     + {2'b00, c.smo} + {2'b00, c.co};
    endfunction

    // Fixed-priority bus owner: RAM > IR low nibble > A > ALU > PC.
    function automatic bus_src_e select_source(input ctrl_t c);
        if (c.ro)       select_source = SRC_RAM;
        else if (c.io)  select_source = SRC_IR;
        else if (c.ao)  select_source = SRC_A;
        else if (c.smo) select_source = SRC_ALU;
        else if (c.co)  select_source = SRC_PC;
        else            select_source = SRC_NONE;
    endfunction

endpackage

// File: rtl/sap_datapath_if.sv
// Control, program-load and status signals between controller/loader and datapath.
// Latency: n/a (wiring bundle only).
// Backpressure: none; the datapath consumes a control word every clock.
interface sap_datapath_if;
    import sap_pkg::*;

    logic [CW_W-1:0]       cbus;
    logic                  prog_mode;
    logic                  prog_we;
    logic [SAP_ADDR_W-1:0] prog_addr;
    logic [SAP_DATA_W-1:0] prog_data;

    logic [3:0]            instruction;
    logic [SAP_DATA_W-1:0] out_value;
    logic                  halted;
    logic                  carry;
    logic                  zero;
    logic                  bus_conflict;
    logic [SAP_DATA_W-1:0] bus_value;

    // Controller / program loader side.
    modport master (
        output cbus, prog_mode, prog_we, prog_addr, prog_data,
        input  instruction, out_value, halted, carry, zero, bus_conflict, bus_value
    );

    // Datapath side.
    modport slave (
        input  cbus, prog_mode, prog_we, prog_addr, prog_data,
        output instruction, out_value, halted, carry, zero, bus_conflict, bus_value
    );

endinterface

// File: rtl/sap_alu.sv
// Combinational adder/subtractor on the registered A and B values.
// Latency: zero cycles (pure combinational).
// Backpressure: none.
module sap_alu
    import sap_pkg::*;
#(
    parameter int DATA_W = SAP_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W-1:0] b_op;
    logic [DATA_W:0]   sum;

    // Subtraction is A + ~B + 1, so carry=1 on subtract means no borrow.
    always_comb begin
        b_op   = sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_op} + {{DATA_W{1'b0}}, sub};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
    end

endmodule

// File: rtl/sap_datapath.sv
// SAP-1 datapath: PC, MAR, RAM, IR, A, B, ALU, output and halt on one 8-bit bus.
// Latency: every latch captures the current bus on the rising edge the word is present.
// Backpressure: none; cbus ignored while prog_mode is high or after halt.
module sap_datapath
    import sap_pkg::*;
#(
    parameter int RAM_DEPTH = SAP_RAM_DEPTH,
    parameter int DATA_W    = SAP_DATA_W
) (
    input  logic           clk,
    input  logic           reset,
    sap_datapath_if.slave  dp
);

    ctrl_t                 cw;
    logic                  run;
    bus_src_e              src;
    logic [DATA_W-1:0]     bus;
    logic                  multi_drive;

    logic [SAP_ADDR_W-1:0] pc;
    logic [SAP_ADDR_W-1:0] mar;
    logic [DATA_W-1:0]     ir;
    logic [DATA_W-1:0]     a_reg;
    logic [DATA_W-1:0]     b_reg;
    logic [DATA_W-1:0]     out_reg;
    logic                  halted;
    logic                  carry_flag;
    logic                  zero_flag;
    logic                  conflict_flag;

    logic [DATA_W-1:0]     ram [RAM_DEPTH];

    logic [DATA_W-1:0]     alu_result;
    logic                  alu_carry;
    logic                  unused_rsvd;

    assign cw          = ctrl_t'(dp.cbus);
    assign unused_rsvd = ^cw.rsvd;

    // Control words only take effect when the loader is idle and we have not halted.
    assign run = !dp.prog_mode && !halted;

    sap_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (a_reg),
        .b      (b_reg),
        .sub    (cw.sub),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // Bus mux: highest-priority requested source wins; idle bus and load mode read zero.
    always_comb begin
        src         = select_source(cw);
        multi_drive = (driver_count(cw) >= 3'd2);
        bus         = '0;
        if (!dp.prog_mode) begin
            case (src)
                SRC_RAM:  bus = ram[mar];
                SRC_IR:   bus = {{(DATA_W-4){1'b0}}, ir[3:0]};
                SRC_A:    bus = a_reg;
                SRC_ALU:  bus = alu_result;
                SRC_PC:   bus = {{(DATA_W-SAP_ADDR_W){1'b0}}, pc};
                default:  bus = '0;
            endcase
        end
    end

    // Register latches; all sample the same pre-edge bus, so source==dest is safe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= '0;
            mar           <= '0;
            ir            <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            out_reg       <= '0;
            halted        <= 1'b0;
            carry_flag    <= 1'b0;
            zero_flag     <= 1'b0;
            conflict_flag <= 1'b0;
        end else if (run) begin
            if (cw.halt) halted  <= 1'b1;
            if (cw.mi)   mar     <= bus[SAP_ADDR_W-1:0];
            if (cw.ii)   ir      <= bus;
            if (cw.ai)   a_reg   <= bus;
            if (cw.bi)   b_reg   <= bus;
            if (cw.oi)   out_reg <= bus;
            if (cw.ce)   pc      <= pc + 1'b1;
            // Flags only track an ALU result actually written back into A.
            if (cw.ai && src == SRC_ALU) begin
                carry_flag <= alu_carry;
                zero_flag  <= (bus == '0);
            end
            if (multi_drive) conflict_flag <= 1'b1;
        end
    end

    // RAM port: bus write from the program, or loader write while in prog_mode; never reset.
    always_ff @(posedge clk) begin
        if (!reset && run && cw.ri) begin
            ram[mar] <= bus;
        end else if (dp.prog_mode && dp.prog_we) begin
            ram[dp.prog_addr] <= dp.prog_data;
        end
    end

    assign dp.instruction  = ir[7:4];
    assign dp.out_value    = out_reg;
    assign dp.halted       = halted;
    assign dp.carry        = carry_flag;
    assign dp.zero         = zero_flag;
    assign dp.bus_conflict = conflict_flag;
    assign dp.bus_value    = bus;

endmodule

// File: tb/tb_sap_datapath.sv
// Directed bench for sap_datapath with a queue-based scoreboard and negedge monitor.
// Registers without a port (A, B, PC, RAM) are observed by putting them on the bus.
// Stimulus changes 2 ns after each rising edge; the monitor samples on falling edges.
module tb_sap_datapath;
    import sap_pkg::*;

    localparam logic [2:0] F_BUS   = 3'd0;
    localparam logic [2:0] F_INSTR = 3'd1;
    localparam logic [2:0] F_OUT   = 3'd2;
    localparam logic [2:0] F_HALT  = 3'd3;
    localparam logic [2:0] F_CARRY = 3'd4;
    localparam logic [2:0] F_ZERO  = 3'd5;
    localparam logic [2:0] F_CONF  = 3'd6;

    typedef struct {
        string      name;
        logic [2:0] field;
        logic [7:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    sap_datapath_if dpi ();

    sap_datapath dut (
        .clk   (clk),
        .reset (reset),
        .dp    (dpi)
    );

    // Monitor: one expectation is retired per falling edge.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] act;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.field)
                F_BUS:   act = dpi.bus_value;
                F_INSTR: act = {4'h0, dpi.instruction};
                F_OUT:   act = dpi.out_value;
                F_HALT:  act = {7'h0, dpi.halted};
                F_CARRY: act = {7'h0, dpi.carry};
                F_ZERO:  act = {7'h0, dpi.zero};
                F_CONF:  act = {7'h0, dpi.bus_conflict};
                default: act = 8'hxx;
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %02h expected %02h", e.name, act, e.val);
            end
        end
    end

    // Apply one control word for exactly one rising edge.
    task automatic step(input logic [15:0] cw);
        dpi.cbus = cw;
        @(posedge clk);
        #2;
        dpi.cbus = '0;
    endtask

    // Drive a probe word (must not latch anything), queue the expectation, advance a cycle.
    task automatic chk(input logic [15:0] cw, input logic [2:0] field,
                       input logic [7:0] val, input string name);
        exp_t e;
        e.name  = name;
        e.field = field;
        e.val   = val;
        dpi.cbus = cw;
        sb.push_back(e);
        @(posedge clk);
        #2;
        dpi.cbus = '0;
    endtask

    task automatic prog(input logic [3:0] addr, input logic [7:0] data);
        dpi.prog_mode = 1'b1;
        dpi.prog_we   = 1'b1;
        dpi.prog_addr = addr;
        dpi.prog_data = data;
        @(posedge clk);
        #2;
        dpi.prog_mode = 1'b0;
        dpi.prog_we   = 1'b0;
    endtask

    task automatic fetch();
        step(M_CO | M_MI);
        step(M_RO | M_II | M_CE);
    endtask

    // MAR is parked at 12, so RAM[12] acts as an immediate-value slot.
    task automatic load_reg(input logic [7:0] v, input logic [15:0] dst);
        prog(4'd12, v);
        step(M_RO | dst);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        dpi.cbus      = '0;
        dpi.prog_mode = 1'b0;
        dpi.prog_we   = 1'b0;
        dpi.prog_addr = '0;
        dpi.prog_data = '0;
        @(posedge clk);
        #2;

        // Reset state.
        chk(M_AO, F_BUS,   8'h00, "rst_a");
        chk(M_CO, F_BUS,   8'h00, "rst_pc");
        chk('0,   F_INSTR, 8'h00, "rst_instr");
        chk('0,   F_HALT,  8'h00, "rst_halted");
        chk('0,   F_CONF,  8'h00, "rst_conflict");
        reset = 1'b0;

        // Program: LDA 14; LDA 13; ADD 15; data at 13/14/15.
        prog(4'd0,  8'h1E);
        prog(4'd1,  8'h1D);
        prog(4'd2,  8'h2F);
        prog(4'd13, 8'hF0);
        prog(4'd14, 8'h2A);
        // Load mode: bus reads zero and the noisy cbus must have no effect.
        dpi.prog_mode = 1'b1;
        dpi.prog_we   = 1'b1;
        dpi.prog_addr = 4'd15;
        dpi.prog_data = 8'h20;
        chk(M_CE | M_RO | M_AO | M_AI, F_BUS, 8'h00, "prog_bus_zero");
        dpi.prog_mode = 1'b0;
        dpi.prog_we   = 1'b0;

        // Fetch + LDA 14.
        fetch();
        chk('0, F_INSTR, 8'h01, "lda_instr");
        step(M_IO | M_MI);
        step(M_RO | M_AI);
        chk(M_AO, F_BUS,  8'h2A, "lda_a");
        chk(M_CO, F_BUS,  8'h01, "lda_pc");
        chk('0,   F_CONF, 8'h00, "lda_conflict");

        // Fetch + LDA 13 -> A=F0.
        fetch();
        step(M_IO | M_MI);
        step(M_RO | M_AI);
        chk(M_AO, F_BUS, 8'hF0, "lda2_a");

        // Fetch + ADD 15: F0 + 20 wraps to 10 with carry.
        fetch();
        chk('0, F_INSTR, 8'h02, "add_instr");
        step(M_IO | M_MI);
        step(M_RO | M_BI);
        step(M_SMO | M_AI);
        chk(M_AO, F_BUS,   8'h10, "add_a");
        chk('0,   F_CARRY, 8'h01, "add_carry");
        chk('0,   F_ZERO,  8'h00, "add_zero");

        // Park MAR at 12.
        prog(4'd15, 8'h0C);
        step(M_RO | M_MI);

        // 5 - 7 = FE with borrow.
        load_reg(8'h05, M_AI);
        load_reg(8'h07, M_BI);
        step(M_SMO | M_SUB | M_AI);
        chk(M_AO, F_BUS,   8'hFE, "sub_a");
        chk('0,   F_CARRY, 8'h00, "sub_carry");
        chk('0,   F_ZERO,  8'h00, "sub_zero");

        // 7 - 7 = 0, no borrow.
        load_reg(8'h07, M_AI);
        step(M_SMO | M_SUB | M_AI);
        chk(M_AO, F_BUS,   8'h00, "sub0_a");
        chk('0,   F_ZERO,  8'h01, "sub0_zero");
        chk('0,   F_CARRY, 8'h01, "sub0_carry");

        // PC is 3: thirteen increments wrap it through 15 to 0.
        repeat (13) step(M_CE);
        chk(M_CO, F_BUS, 8'h00, "pc_wrap");

        // Plain bus load of A leaves flags alone; then OUT.
        load_reg(8'h5A, M_AI);
        chk('0, F_ZERO, 8'h01, "zero_hold");
        step(M_AO | M_OI);
        chk('0, F_OUT, 8'h5A, "out_value");

        // Conflict: RAM outranks A, so B gets C4 (A+B = 33+C4 = F7).
        load_reg(8'h33, M_AI);
        prog(4'd12, 8'hC4);
        step(M_RO | M_AO | M_BI);
        chk(M_SMO, F_BUS,  8'hF7, "conflict_b");
        chk('0,    F_CONF, 8'h01, "conflict_flag");

        // PC to 7, then halt; the halting edge still executes OI.
        repeat (7) step(M_CE);
        step(M_HALT | M_AO | M_OI);
        step(M_CE | M_AI);
        chk('0,   F_HALT, 8'h01, "halted");
        chk('0,   F_OUT,  8'h33, "halt_edge_out");
        chk(M_CO, F_BUS,  8'h07, "halt_pc");
        chk(M_AO, F_BUS,  8'h33, "halt_a");
        prog(4'd1, 8'h77);

        // Asynchronous reset between edges; first sample precedes any rising edge.
        reset = 1'b1;
        chk(M_AO, F_BUS,  8'h00, "arst_a");
        chk(M_CO, F_BUS,  8'h00, "arst_pc");
        chk('0,   F_HALT, 8'h00, "arst_halted");
        chk('0,   F_CONF, 8'h00, "arst_conflict");
        chk('0,   F_OUT,  8'h00, "arst_out");
        reset = 1'b0;

        // RAM survives reset, including the write made while halted.
        chk(M_RO, F_BUS, 8'h1E, "ram_keep");
        step(M_CE);
        step(M_CO | M_MI);
        chk(M_RO, F_BUS, 8'h77, "prog_while_halted");

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
            errors += sb.size();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sap_datapath.md
Name: sap_datapath

Overview:
SAP-1 datapath that executes the 16-bit control word produced by sap_control_logic. It holds the program counter, the memory address register (MAR), a 16x8 RAM, the instruction register (IR), the A and B registers, the adder/subtractor ALU, the output register and the halt latch, all connected by an 8-bit shared bus. It returns the IR opcode nibble to the controller. A program-load port fills RAM before a run.

Parameters:
- RAM_DEPTH, 16, number of RAM words; the address width is 4 bits (fixed).
- DATA_W, 8, width of the bus and of every data register.

Ports:
- clk  in  1  system clock; datapath registers update on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cbus  in  16  control word. Bit 15 HALT, 14 MI, 13 RI, 12 RO, 11 instruction_out (IR[3:0] to bus), 10 instruction_latch, 9 AI, 8 AO, 7 SMO, 6 SUB, 5 BI, 4 OI, 3 CE, 2 CO. Bits 1:0 are reserved and ignored.
- prog_mode  in  1  high: RAM is written from the prog_* ports and cbus is ignored.
- prog_we  in  1  RAM write strobe, sampled only when prog_mode is high.
- prog_addr  in  4  program-load address.
- prog_data  in  8  program-load data.
- instruction  out  4  IR[7:4], the opcode sent to the controller.
- out_value  out  8  output register contents.
- halted  out  1  sticky halt flag.
- carry  out  1  ALU carry, latched when A loads from the ALU.
- zero  out  1  high when the latched A result is 0x00.
- bus_conflict  out  1  sticky flag: more than one bus driver was asserted.
- bus_value  out  8  current combinational bus value, for debug.

Behaviour:
- Reset (asynchronous) clears to 0: PC, MAR, IR, A, B, out_value, halted, carry, zero, bus_conflict.
  - RAM is never reset.
  - instruction therefore reads 0 during reset.
- Bus drivers and priority: RO (RAM[MAR]) > instruction_out ({4'h0, IR[3:0]}) > AO (A) > SMO (ALU) > CO ({4'h0, PC}).
  - With no driver asserted, the bus reads 0x00.
  - bus_conflict sets on any rising edge where two or more drivers are asserted, while not halted and not in prog_mode. It stays set until reset.
- ALU is combinational on the current A and B:
  - SUB=0: A+B, 9-bit result.
  - SUB=1: A+~B+1, 9-bit result.
  - The ALU output is the low 8 bits. Results wrap modulo 256.
  - ALU carry is bit 8 of the result. For subtraction, carry=1 means no borrow.
- Latches act at the rising edge, and all of them sample the same bus value:
  - MI: MAR<=bus[3:0].
  - RI: RAM[MAR]<=bus.
  - instruction_latch: IR<=bus.
  - AI: A<=bus.
  - BI: B<=bus.
  - OI: out_value<=bus.
  - CE: PC<=PC+1, wrapping 15 to 0.
- Simultaneous source and destination (for example AO|AI, or SMO|AI): the destination captures the pre-edge value. No combinational loop exists because the ALU and the bus read registered values only.
- carry and zero update only on an edge where AI and SMO are both asserted and SMO is the selected driver. zero is set from the captured ALU result. At all other times both flags hold.
- HALT sampled high at a rising edge sets halted in that same edge; the other latches in that edge are still executed.
  - Once halted=1, every latch and CE is ignored until reset.
  - prog_mode still works while halted.
- prog_mode=1:
  - cbus is fully ignored: no latch, no CE, no conflict detection.
  - prog_we=1 writes RAM[prog_addr]<=prog_data at the edge.
  - bus_value reads 0x00.
- RI and prog_we never collide, because prog_mode gates RI.
- Reset asserted mid-instruction clears registers immediately (asynchronously). RAM contents are preserved. Operation resumes on the first rising edge after reset deasserts.
- The controller drives cbus from the falling edge, so cbus is stable at every rising edge. There is zero-cycle latency from cbus to the latch.

Decomposition:
- Shared package sap_pkg holds:
  - control-bit index constants (HALT=15 ... CO=2) and the 16-bit control-word masks;
  - the opcode constants LDA=4'b0001, ADD=4'b0010, OUT=4'b1110;
  - the DATA_W and address-width constants.
- The controller should import sap_pkg too, so the bit map is defined once.
- One natural sub-module: sap_alu, a combinational add/subtract that returns an 8-bit result plus carry. Everything else stays in sap_datapath.

Test Plan:
- Program load then LDA: prog-write RAM[0]=0x1E and RAM[14]=0x2A, then drive the fetch, decode and LDA control words. Required: instruction=0x1, A=0x2A, PC=1, bus_conflict=0.
- ADD wrap: A=0xF0, RAM[15]=0x20, then run the ADD micro-steps (instruction_out|MI, RO|BI, SMO|AI). Required: A=0x10, carry=1, zero=0.
- Subtract: A=0x05, B=0x07, then cbus=SMO|SUB|AI. Required: A=0xFE, carry=0. Follow with A=0x07, B=0x07 and the same word. Required: A=0x00, zero=1, carry=1.
- PC wrap and OUT: apply CE 16 times. Required: PC back to 0. Then A=0x5A with cbus=AO|OI. Required: out_value=0x5A.
- Conflict and halt: cbus=RO|AO|BI. Required: B=RAM[MAR], bus_conflict=1. Next cbus=HALT, then CE|AI. Required: halted=1, PC and A unchanged.
- Async reset mid-run: assert reset between edges while A=0x33 and PC=7. Required: A=0, PC=0, halted=0 immediately, with RAM contents intact.
